// File: rtl/floo_axis_rx_splitter.sv
// Receive-side splitter: unpacks AXIS beats carrying an optional req and rsp flit
// into two independently buffered, independently flow-controlled flit streams.

// Handshake rule on every port pair: a transfer happens on a rising edge where
// valid and ready are both high; valid never waits on ready, and the payload
// holds steady while valid is high and ready is low.

module floo_axis_rx_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [Width-1:0]           data_o,
  output logic [$clog2(Depth):0]     usage_o,
  output logic                       full_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned UW = AW + 1;
  localparam logic [UW-1:0] FullLevel = UW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;

  assign valid_o = (usage_o != '0);
  assign full_o  = (usage_o == FullLevel);
  assign data_o  = mem[rd_ptr];
  assign pop     = valid_o & ready_i;

  // Storage is deliberately left out of reset; only the bookkeeping is cleared.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usage_o <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (push_i && !pop)      usage_o <= usage_o + 1'b1;
      else if (!push_i && pop) usage_o <= usage_o - 1'b1;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) push_i |-> !full_o);
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) pop |-> (usage_o != '0));
  a_out_stable:   assert property (@(posedge clk_i) disable iff (rst_i)
                                   (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));
endmodule

module floo_axis_rx_splitter #(
  parameter int unsigned ReqDataWidth = 64,
  parameter int unsigned RspDataWidth = 64,
  parameter int unsigned Depth        = 4,
  parameter int unsigned CntWidth     = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   axis_tvalid_i,
  output logic                                   axis_tready_o,
  input  logic [ReqDataWidth+RspDataWidth+1:0]   axis_tdata_i,
  output logic                                   req_valid_o,
  input  logic                                   req_ready_i,
  output logic [ReqDataWidth-1:0]                req_data_o,
  output logic                                   rsp_valid_o,
  input  logic                                   rsp_ready_i,
  output logic [RspDataWidth-1:0]                rsp_data_o,
  output logic [$clog2(Depth):0]                 req_usage_o,
  output logic [$clog2(Depth):0]                 rsp_usage_o,
  output logic [CntWidth-1:0]                    empty_beats_o
);
  logic                    req_full, rsp_full;
  logic                    accept;
  logic                    req_bit, rsp_bit;
  logic [ReqDataWidth-1:0] beat_req_data;
  logic [RspDataWidth-1:0] beat_rsp_data;

  assign rsp_bit       = axis_tdata_i[0];
  assign beat_rsp_data = axis_tdata_i[RspDataWidth:1];
  assign req_bit       = axis_tdata_i[RspDataWidth+1];
  assign beat_req_data = axis_tdata_i[RspDataWidth+ReqDataWidth+1:RspDataWidth+2];

  // tready looks only at registered fullness, so neither downstream ready
  // reaches the link; a full FIFO costs a one-cycle bubble even if it pops.
  assign axis_tready_o = !rst_i & !req_full & !rsp_full;
  assign accept        = axis_tvalid_i & axis_tready_o;

  floo_axis_rx_fifo #(.Width(ReqDataWidth), .Depth(Depth)) i_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept & req_bit),
    .data_i  (beat_req_data),
    .valid_o (req_valid_o),
    .ready_i (req_ready_i),
    .data_o  (req_data_o),
    .usage_o (req_usage_o),
    .full_o  (req_full)
  );

  floo_axis_rx_fifo #(.Width(RspDataWidth), .Depth(Depth)) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept & rsp_bit),
    .data_i  (beat_rsp_data),
    .valid_o (rsp_valid_o),
    .ready_i (rsp_ready_i),
    .data_o  (rsp_data_o),
    .usage_o (rsp_usage_o),
    .full_o  (rsp_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      empty_beats_o <= '0;
    end else if (accept && !req_bit && !rsp_bit && (empty_beats_o != '1)) begin
      empty_beats_o <= empty_beats_o + 1'b1;
    end
  end
endmodule

// File: doc/floo_axis_rx_splitter.md
Name: floo_axis_rx_splitter

Overview:
- Receive-side stage between the serial-link AXIS output and the NoC.
- Consumes AXIS beats, each packing one optional req flit and one optional rsp flit.
- Splits them into two independently flow-controlled flit streams, each buffered by its own FIFO.
- This removes the combinational coupling of req and rsp ready onto tready, so a stalled rsp channel never blocks a req flit already buffered, and vice versa.

Parameters:
ReqDataWidth, 64, width of req flit payload (flit minus valid/ready).
RspDataWidth, 64, width of rsp flit payload.
Depth, 4, entries per channel FIFO; power of two, >= 2.
CntWidth, 16, width of the dropped-empty-beat counter.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous reset, active-high.
axis_tvalid_i  in  1  AXIS beat valid.
axis_tready_o  out  1  AXIS beat accept.
axis_tdata_i  in  ReqDataWidth+RspDataWidth+2  packed beat {req_data, req_valid, rsp_data, rsp_valid}, MSB first.
req_valid_o  out  1  req flit valid toward NoC.
req_ready_i  in  1  NoC accepts req flit.
req_data_o  out  ReqDataWidth  req flit payload.
rsp_valid_o  out  1  rsp flit valid toward NoC.
rsp_ready_i  in  1  NoC accepts rsp flit.
rsp_data_o  out  RspDataWidth  rsp flit payload.
req_usage_o  out  $clog2(Depth)+1  req FIFO occupancy.
rsp_usage_o  out  $clog2(Depth)+1  rsp FIFO occupancy.
empty_beats_o  out  CntWidth  count of accepted beats with both valid bits 0, saturating.

Behaviour:
- Bit mapping of axis_tdata_i:
  - bit 0 = rsp_valid
  - [RspDataWidth:1] = rsp_data
  - bit RspDataWidth+1 = req_valid
  - [RspDataWidth+ReqDataWidth+1:RspDataWidth+2] = req_data
- Reset (rst_i high at a clock edge):
  - FIFO pointers and usage cleared to 0; empty_beats_o = 0.
  - req_valid_o = rsp_valid_o = 0.
  - axis_tready_o forced 0 while rst_i is high.
  - Stored data is not cleared; data outputs are don't-care while the corresponding valid is 0.
  - Reset mid-operation discards all buffered flits; no partial beat survives.
- axis_tready_o = !rst_i & !req_full & !rsp_full.
  - Depends only on registered state, never on tdata, tvalid or downstream ready.
  - A full FIFO deasserts tready even if it pops in the same cycle (no bypass). This is a one-cycle bubble, accepted.
- Beat accept = axis_tvalid_i & axis_tready_o. On accept:
  - push req_data into the req FIFO iff req_valid bit = 1;
  - push rsp_data into the rsp FIFO iff rsp_valid bit = 1;
  - both pushes happen in the same cycle when both bits are set;
  - if both bits are 0, nothing is pushed and empty_beats_o increments, saturating at 2^CntWidth-1.
- Output side per channel: valid_o = (usage != 0); data_o = head entry. Pop on valid_o & ready_i.
- Latency: beat accepted at edge N produces flit valid from cycle N+1 if the FIFO was empty. No combinational path from tdata to flit outputs.
- Simultaneous push and pop on a non-full, non-empty FIFO: usage unchanged; order preserved.
- Pop from empty is impossible, since valid_o is 0.
- Overflow is impossible, since tready is gated by full.
- Pointers are $clog2(Depth) bits and wrap modulo Depth. full = (usage == Depth), empty = (usage == 0).
- Each channel is strictly FIFO-ordered. There is no ordering guarantee between the req and rsp channels.
- Throughput: with Depth >= 2 and both downstream ready held high, one beat per cycle is sustained indefinitely.
- Flit outputs obey valid/ready stability: once valid_o is high, data_o is stable and valid_o stays high until the pop.
- Assertions:
  - no push to a full FIFO;
  - no pop from an empty FIFO;
  - flit outputs stable while valid & !ready.

Test Plan:
1. Reset then idle: rst_i high 3 cycles with tvalid=1 -> tready=0, both flit valids 0, usages 0, empty_beats 0. After release, tready=1 next cycle.
2. Streaming: 10 back-to-back beats with both valid bits set (req_data=i, rsp_data=0x100+i), both readies high -> tready constantly 1; req outputs 0..9 and rsp outputs 0x100..0x109 in order, each 1 cycle after accept.
3. Decoupling: rsp_ready_i=0, 6 beats with both bits set, Depth=4 -> 4 beats accepted, then tready=0 and rsp_usage=4. req_data_o delivers all 4 req flits regardless. Raising rsp_ready resumes acceptance 1 cycle after the first pop.
4. Single-channel and empty beats: alternate req-only, rsp-only and empty beats (8 total, 3 empty) -> each FIFO receives only its flagged flits; empty_beats_o=3.
5. Saturation: CntWidth=4, 20 empty beats -> empty_beats_o holds at 15.
6. Reset mid-operation: both FIFOs at usage 3, assert rst_i for 1 cycle -> usages 0 and valids 0 next cycle. No pre-reset data ever appears after reset.
